// File: rtl/soc_system_fifo_h2f_out.sv
// Avalon-ST sink to Avalon-MM read slave packet FIFO.
// CPU pops byte-swapped words, peeks head flags and polls fill status.
module soc_system_fifo_h2f_out #(
  parameter int DEPTH  = 8,
  parameter int DEPTHU = 3
) (
  input  logic        rdclock,
  input  logic        reset_n,
  input  logic [31:0] avalonst_sink_data,
  input  logic        avalonst_sink_valid,
  input  logic        avalonst_sink_startofpacket,
  input  logic        avalonst_sink_endofpacket,
  input  logic [1:0]  avalonst_sink_empty,
  output logic        avalonst_sink_ready,
  input  logic [1:0]  avalonmm_read_slave_address,
  input  logic        avalonmm_read_slave_read,
  output logic [31:0] avalonmm_read_slave_readdata
);

  localparam logic [DEPTHU:0]   CNT_ONE  = 1;
  localparam logic [DEPTHU:0]   CNT_FULL = (DEPTHU+1)'(DEPTH);
  localparam logic [DEPTHU-1:0] PTR_ONE  = 1;

  logic [35:0]       mem_q [DEPTH];
  logic [DEPTHU-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTHU-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTHU:0]   count_q, count_d;
  logic              ready_q, ready_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        push, pop, not_empty, full;
  logic [35:0] head;
  logic [31:0] status;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_FULL);
  assign head      = mem_q[rd_ptr_q];
  assign push      = avalonst_sink_valid & ready_q;
  assign pop       = avalonmm_read_slave_read
                   & (avalonmm_read_slave_address == 2'd0)
                   & not_empty;

  always_comb begin
    status             = '0;
    status[DEPTHU:0]   = count_q;
    status[16]         = full;
    status[17]         = ~not_empty;
    status[24]         = ovf_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    ready_d = (count_d != CNT_FULL);
  end

  // a fresh overflow beats the clear-on-read of the status word
  always_comb begin
    ovf_d = ovf_q;
    if (avalonst_sink_valid && !ready_q)
      ovf_d = 1'b1;
    else if (avalonmm_read_slave_read &&
             avalonmm_read_slave_address == 2'd2)
      ovf_d = 1'b0;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avalonmm_read_slave_read) begin
      unique case (avalonmm_read_slave_address)
        2'd0: rdata_d = not_empty
          ? {head[7:0], head[15:8], head[23:16], head[31:24]}
          : '0;
        2'd1: rdata_d = not_empty
          ? {27'b0, 1'b1, head[35:32]}
          : '0;
        2'd2: rdata_d = status;
        2'd3: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge rdclock) begin
    if (push)
      mem_q[wr_ptr_q] <= {avalonst_sink_empty,
                          avalonst_sink_endofpacket,
                          avalonst_sink_startofpacket,
                          avalonst_sink_data};
  end

  always_ff @(posedge rdclock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avalonst_sink_ready          = ready_q;
  assign avalonmm_read_slave_readdata = rdata_q;

endmodule

// File: tb/tb_soc_system_fifo_h2f_out.sv
// Directed bench for soc_system_fifo_h2f_out.
// Hand-computed expectations plus a small queue model for ordering.
module tb_soc_system_fifo_h2f_out;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] st_data;
  logic        st_valid, st_sop, st_eop;
  logic [1:0]  st_empty;
  logic        st_ready;
  logic [1:0]  mm_addr;
  logic        mm_read;
  logic [31:0] mm_rdata;

  int tests  = 0;
  int failed = 0;
  logic [31:0] model [$];
  logic [31:0] held;

  always #5 clk = ~clk;

  soc_system_fifo_h2f_out #(.DEPTH(8), .DEPTHU(3)) dut (
    .rdclock                      (clk),
    .reset_n                      (rst_n),
    .avalonst_sink_data           (st_data),
    .avalonst_sink_valid          (st_valid),
    .avalonst_sink_startofpacket  (st_sop),
    .avalonst_sink_endofpacket    (st_eop),
    .avalonst_sink_empty          (st_empty),
    .avalonst_sink_ready          (st_ready),
    .avalonmm_read_slave_address  (mm_addr),
    .avalonmm_read_slave_read     (mm_read),
    .avalonmm_read_slave_readdata (mm_rdata)
  );

  function automatic logic [31:0] swp(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mm_rd(input logic [1:0] a);
    mm_addr = a;
    mm_read = 1'b1;
    tick();
    mm_read = 1'b0;
  endtask

  task automatic push1(input logic [31:0] d, input logic s,
                       input logic e, input logic [1:0] em);
    st_data  = d;
    st_sop   = s;
    st_eop   = e;
    st_empty = em;
    st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
  endtask

  // one cycle with optional push and pop, checked against the model
  task automatic cyc(input logic do_push, input logic [31:0] d,
                     input logic do_pop);
    logic [31:0] exp;
    st_data  = d;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    st_empty = 2'd0;
    st_valid = do_push;
    mm_addr  = 2'd0;
    mm_read  = do_pop;
    tick();
    st_valid = 1'b0;
    mm_read  = 1'b0;
    if (do_pop) begin
      exp = (model.size() != 0) ? swp(model.pop_front()) : 32'd0;
      chk("wrap_pop", mm_rdata, exp);
    end
    if (do_push) model.push_back(d);
  endtask

  task automatic chk_status(input string tag, input int n);
    logic [31:0] exp;
    exp = 32'(n);
    exp[16] = (n == 8);
    exp[17] = (n == 0);
    mm_rd(2'd2);
    chk(tag, mm_rdata, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    st_data  = '0;
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    st_empty = '0;
    mm_addr  = '0;
    mm_read  = 1'b0;

    // reset and idle
    repeat (3) tick();
    chk("rst_ready", 32'(st_ready), 32'd0);
    chk("rst_rdata", mm_rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_up", 32'(st_ready), 32'd1);
    mm_rd(2'd2);
    chk("idle_status", mm_rdata, 32'h0002_0000);

    // single beat
    push1(32'h1122_3344, 1'b1, 1'b1, 2'd2);
    mm_rd(2'd1);
    chk("single_flags", mm_rdata, 32'h0000_001B);
    mm_rd(2'd0);
    chk("single_data", mm_rdata, 32'h4433_2211);
    mm_rd(2'd2);
    chk("single_status", mm_rdata, 32'h0002_0000);

    // fill and overflow
    st_sop = 1'b0;
    st_eop = 1'b0;
    st_empty = 2'd0;
    st_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      st_data = 32'h0A00_0000 + 32'(i);
      tick();
      if (i == 7) chk("full_ready", 32'(st_ready), 32'd0);
    end
    st_valid = 1'b0;
    mm_rd(2'd2);
    chk("ovf_status", mm_rdata, 32'h0101_0008);
    mm_rd(2'd2);
    chk("ovf_cleared", mm_rdata, 32'h0001_0008);
    held = mm_rdata;
    tick();
    chk("rdata_hold", mm_rdata, held);
    mm_rd(2'd0);
    chk("full_pop0", mm_rdata, swp(32'h0A00_0000));
    chk("ready_after_pop", 32'(st_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      mm_rd(2'd0);
      chk("full_drain", mm_rdata, swp(32'h0A00_0000 + 32'(i)));
    end
    chk_status("drained", 0);

    // wrap and ordering with simultaneous push/pop
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'hC0DE_0000 + 32'(i), (i % 4) != 0);
      chk_status("wrap_status", model.size());
    end
    while (model.size() != 0) cyc(1'b0, 32'd0, 1'b1);
    chk_status("wrap_empty", 0);

    // underflow and reserved address
    mm_rd(2'd0);
    chk("underflow_data", mm_rdata, 32'd0);
    chk_status("underflow_status", 0);
    mm_rd(2'd3);
    chk("addr3", mm_rdata, 32'd0);

    // reset mid-stream
    for (int i = 0; i < 5; i++)
      push1(32'h5500_0000 + 32'(i), 1'b0, 1'b0, 2'd0);
    chk_status("five_stored", 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata", mm_rdata, 32'd0);
    chk("midrst_ready", 32'(st_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_status("midrst_status", 0);
    mm_rd(2'd0);
    chk("midrst_pop", mm_rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
